// File: rtl/wpa2_pio_bridge_pkg.sv
// rtl/wpa2_pio_bridge_pkg.sv - shared FSM encoding and PIO control bit positions
package wpa2_pio_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT,
    ACK
  } state_t;

  localparam int CTL_WR_REQ = 0;
  localparam int CTL_RD_REQ = 1;
  localparam int CTL_ACK    = 0;
  localparam int CTL_ERR    = 1;
  localparam int CTL_DONE   = 2;

endpackage

// File: rtl/wpa2_pio_bridge_timeout.sv
// rtl/wpa2_pio_bridge_timeout.sv - clear/enable cycle counter flagging a channel response timeout
module wpa2_pio_bridge_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Expires in the TIMEOUT-th enabled cycle so the owner leaves on that edge.
  assign expired = en && (count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wpa2_pio_bridge.sv
// rtl/wpa2_pio_bridge.sv - PIO request/ack to per-channel register access bridge
// Optional response timeout enabled by defining WPA2_PIO_BRIDGE_TIMEOUT_EN.
module wpa2_pio_bridge
  import wpa2_pio_bridge_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 8,
  parameter  int NCH     = 4,
  parameter  int TIMEOUT = 255,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int REG_W   = ADDR_W - CH_W
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [ADDR_W-1:0]     address_export,
  input  logic [DATA_W-1:0]     write_export,
  output logic [DATA_W-1:0]     read_export,
  input  logic [1:0]            control_in_export,
  output logic [2:0]            control_out_export,
  output logic [REG_W-1:0]      ch_addr,
  output logic [DATA_W-1:0]     ch_wdata,
  output logic [NCH-1:0]        ch_wr_valid,
  output logic [NCH-1:0]        ch_rd_valid,
  input  logic [NCH-1:0]        ch_ready,
  input  logic [NCH-1:0]        ch_rvalid,
  input  logic [NCH*DATA_W-1:0] ch_rdata,
  input  logic [NCH-1:0]        ch_done
);

  localparam logic [NCH-1:0] ONE_HOT0 = NCH'(1);

  state_t          state;
  logic [CH_W-1:0] sel;
  logic [CH_W-1:0] addr_sel;
  logic [NCH-1:0]  sel_onehot;
  logic            wr_req, rd_req;
  logic            addr_ok, sel_ready, sel_rvalid, tmo;
  logic            ack, err, done;

  assign wr_req     = control_in_export[CTL_WR_REQ];
  assign rd_req     = control_in_export[CTL_RD_REQ];
  assign addr_sel   = address_export[ADDR_W-1:REG_W];
  assign addr_ok    = (32'(addr_sel) < NCH);
  assign sel_onehot = ONE_HOT0 << addr_sel;
  assign sel_ready  = ch_ready[sel];
  assign sel_rvalid = ch_rvalid[sel];

  assign control_out_export[CTL_ACK]  = ack;
  assign control_out_export[CTL_ERR]  = err;
  assign control_out_export[CTL_DONE] = done;

`ifdef WPA2_PIO_BRIDGE_TIMEOUT_EN
  logic tmo_en, tmo_clr;

  // Restart the count on every entry into a waiting state, including RD_ISSUE -> RD_WAIT.
  assign tmo_en  = (state == WR_ISSUE) || (state == RD_ISSUE) || (state == RD_WAIT);
  assign tmo_clr = !tmo_en || ((state == RD_ISSUE) && sel_ready);

  wpa2_pio_bridge_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= IDLE;
      sel         <= '0;
      ch_addr     <= '0;
      ch_wdata    <= '0;
      ch_wr_valid <= '0;
      ch_rd_valid <= '0;
      read_export <= '0;
      ack         <= 1'b0;
      err         <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= |ch_done;
      case (state)
        IDLE: begin
          if (wr_req || rd_req) begin
            sel      <= addr_sel;
            ch_addr  <= address_export[REG_W-1:0];
            ch_wdata <= write_export;
            if ((wr_req && rd_req) || !addr_ok) begin
              err   <= 1'b1;
              ack   <= 1'b1;
              state <= ACK;
            end else if (wr_req) begin
              err         <= 1'b0;
              ch_wr_valid <= sel_onehot;
              state       <= WR_ISSUE;
            end else begin
              err         <= 1'b0;
              ch_rd_valid <= sel_onehot;
              state       <= RD_ISSUE;
            end
          end
        end
        WR_ISSUE, RD_ISSUE: begin
          if (sel_ready) begin
            ch_wr_valid <= '0;
            ch_rd_valid <= '0;
            if (state == WR_ISSUE) begin
              ack   <= 1'b1;
              state <= ACK;
            end else begin
              state <= RD_WAIT;
            end
          end else if (tmo) begin
            ch_wr_valid <= '0;
            ch_rd_valid <= '0;
            err         <= 1'b1;
            ack         <= 1'b1;
            state       <= ACK;
          end
        end
        RD_WAIT: begin
          if (sel_rvalid) begin
            read_export <= ch_rdata[sel*DATA_W +: DATA_W];
            ack         <= 1'b1;
            state       <= ACK;
          end else if (tmo) begin
            err   <= 1'b1;
            ack   <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          if (!wr_req && !rd_req) begin
            ack   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wpa2_pio_bridge.sv
// tb/tb_wpa2_pio_bridge.sv - self-checking bench for wpa2_pio_bridge (NCH=3, TIMEOUT=8)
module tb_wpa2_pio_bridge;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          ready_dly;
    int          rvalid_dly;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  address;
  logic [31:0] wdata;
  logic [31:0] read_export;
  logic [1:0]  ctl;
  logic [2:0]  ctl_out;
  logic [5:0]  ch_addr;
  logic [31:0] ch_wdata;
  logic [2:0]  ch_wr_valid;
  logic [2:0]  ch_rd_valid;
  logic [2:0]  ch_ready;
  logic [2:0]  ch_rvalid;
  logic [95:0] ch_rdata;
  logic [2:0]  ch_done;
  logic        ack, err, done;

  int   n_checks = 0;
  int   n_fail   = 0;
  sb_t  exp_q[$];
  logic [31:0] exp_rd_now = 32'h0;
  logic ack_q;
  vec_t vecs[8];

  assign ack  = ctl_out[0];
  assign err  = ctl_out[1];
  assign done = ctl_out[2];

  wpa2_pio_bridge #(.DATA_W(32), .ADDR_W(8), .NCH(3), .TIMEOUT(8)) dut (
    .clk_clk            (clk),
    .reset_reset_n      (rst_n),
    .address_export     (address),
    .write_export       (wdata),
    .read_export        (read_export),
    .control_in_export  (ctl),
    .control_out_export (ctl_out),
    .ch_addr            (ch_addr),
    .ch_wdata           (ch_wdata),
    .ch_wr_valid        (ch_wr_valid),
    .ch_rd_valid        (ch_rd_valid),
    .ch_ready           (ch_ready),
    .ch_rvalid          (ch_rvalid),
    .ch_rdata           (ch_rdata),
    .ch_done            (ch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_rdata(input logic [2:0] oh, input logic [31:0] d);
    for (int i = 0; i < 3; i++)
      ch_rdata[i*32 +: 32] = oh[i] ? d : (32'hDEAD0000 | 32'(i));
  endtask

  // Scoreboard: each ack rising edge consumes one expected {err, read_export}.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
    end else begin
      if (ack && !ack_q) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_ack: got ack with empty queue");
        end else begin
          sb_t e;
          e = exp_q.pop_front();
          chk("sb_err", 64'(err), 64'(e.err));
          chk("sb_read_export", 64'(read_export), 64'(e.rd));
        end
      end
      ack_q <= ack;
    end
  end

  task automatic do_txn(input vec_t v);
    logic [2:0] oh;
    int         s;
    s  = int'(v.addr[7:6]);
    oh = (s < 3) ? 3'(1 << s) : 3'b000;
    exp_q.push_back({v.exp_err, v.exp_rd});
    address   = v.addr;
    wdata     = v.wdata;
    ctl       = {v.rd, v.wr};
    ch_ready  = ~oh;
    ch_rvalid = 3'b111;
    fill_rdata(oh, ~v.rdata);
    @(negedge clk);
    if (!v.exp_err) begin
      for (int c = 1; c <= v.ready_dly; c++) begin
        chk("issue_valid", 64'({ch_rd_valid, ch_wr_valid}), v.rd ? 64'({oh, 3'b000}) : 64'({3'b000, oh}));
        chk("issue_ch_addr", 64'(ch_addr), 64'(v.addr[5:0]));
        if (v.wr) chk("issue_ch_wdata", 64'(ch_wdata), 64'(v.wdata));
        chk("issue_ack_low", 64'(ack), 64'(0));
        if (c == v.ready_dly) ch_ready = 3'b111;
        @(negedge clk);
      end
      ch_ready = ~oh;
      if (v.rd) begin
        for (int c = 1; c <= v.rvalid_dly; c++) begin
          chk("wait_valid_low", 64'({ack, ch_rd_valid, ch_wr_valid}), 64'(0));
          ch_rvalid = ~oh;
          if (c == v.rvalid_dly) begin
            ch_rvalid = 3'b111;
            fill_rdata(oh, v.rdata);
          end
          @(negedge clk);
        end
      end
    end
    ch_rvalid = ~oh;
    fill_rdata(oh, ~v.rdata);
    chk("ack_set", 64'(ack), 64'(1));
    chk("ack_err", 64'(err), 64'(v.exp_err));
    chk("ack_valids_low", 64'({ch_rd_valid, ch_wr_valid}), 64'(0));
    chk("ack_read_export", 64'(read_export), 64'(v.exp_rd));
    @(negedge clk);
    chk("ack_held", 64'(ack), 64'(1));
    ctl = 2'b00;
    @(negedge clk);
    chk("ack_drop", 64'(ack), 64'(0));
    chk("err_hold", 64'(err), 64'(v.exp_err));
    exp_rd_now = v.exp_rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h41, 32'h12345678, 3, 0, 32'h0,        1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 8'h82, 32'h0,        1, 2, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
    vecs[2] = '{1'b1, 1'b1, 8'h00, 32'h11111111, 0, 0, 32'h0,        1'b1, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 1'b0, 8'hC0, 32'h22222222, 0, 0, 32'h0,        1'b1, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b1, 8'hC5, 32'h0,        0, 0, 32'h0,        1'b1, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 1'b1, 8'h3F, 32'h0,        2, 1, 32'h0BADBEEF, 1'b0, 32'h0BADBEEF};
    vecs[6] = '{1'b1, 1'b0, 8'h95, 32'hA5A5A5A5, 1, 0, 32'h0,        1'b0, 32'h0BADBEEF};
    vecs[7] = '{1'b0, 1'b1, 8'h7F, 32'h0,        1, 1, 32'h13579BDF, 1'b0, 32'h13579BDF};

    rst_n = 1'b0; address = '0; wdata = '0; ctl = '0;
    ch_ready = '0; ch_rvalid = '0; ch_rdata = '0; ch_done = 3'b111;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({read_export, ctl_out, ch_wr_valid, ch_rd_valid}), 64'(0));
    chk("reset_ch_bus", 64'({ch_addr, ch_wdata}), 64'(0));
    ch_done = 3'b000;
    rst_n   = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_txn(vecs[i]);

    ch_done = 3'b100;
    #1 chk("done_lag", 64'(done), 64'(0));
    @(negedge clk);
    chk("done_rise", 64'(done), 64'(1));
    ch_done = 3'b000;
    @(negedge clk);
    chk("done_fall", 64'(done), 64'(0));

    // Request withdrawn mid-write: the write still completes, ack lasts one cycle.
    exp_q.push_back({1'b0, exp_rd_now});
    address = 8'h81; wdata = 32'h00000001; ctl = 2'b01; ch_ready = 3'b000;
    @(negedge clk);
    chk("drop_valid", 64'(ch_wr_valid), 64'(3'b100));
    ctl = 2'b00;
    repeat (2) @(negedge clk);
    chk("drop_valid_held", 64'({ack, ch_wr_valid}), 64'(4'b0100));
    ch_ready = 3'b100;
    @(negedge clk);
    ch_ready = 3'b000;
    chk("drop_ack", 64'({ack, err}), 64'(2'b10));
    @(negedge clk);
    chk("drop_ack_one_cycle", 64'(ack), 64'(0));

    // Reset asserted while waiting for read data.
    ch_done = 3'b001; address = 8'h45; wdata = 32'hFFFF0000; ctl = 2'b10;
    ch_ready = 3'b111; ch_rvalid = 3'b000;
    @(negedge clk);
    chk("rst_pre_valid", 64'(ch_rd_valid), 64'(3'b010));
    ctl = 2'b00;
    @(negedge clk);
    chk("rst_pre_wait", 64'({ack, ch_rd_valid}), 64'(0));
    chk("rst_pre_done", 64'(done), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_read_export", 64'(read_export), 64'(0));
    chk("rst_ctl_out", 64'(ctl_out), 64'(0));
    chk("rst_ch_bus", 64'({ch_addr, ch_wdata, ch_wr_valid, ch_rd_valid}), 64'(0));
    ch_done = 3'b000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; ch_rvalid = 3'b111;
    repeat (3) @(negedge clk);
    chk("rst_stays_idle", 64'({ack, ch_wr_valid, ch_rd_valid}), 64'(0));
    do_txn(vecs[7]);

`ifdef WPA2_PIO_BRIDGE_TIMEOUT_EN
    exp_q.push_back({1'b1, exp_rd_now});
    address = 8'h05; ctl = 2'b10; ch_ready = 3'b110; ch_rvalid = 3'b111;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("tmo_valid_held", 64'({ack, ch_rd_valid}), 64'(4'b0001));
    end
    @(negedge clk);
    chk("tmo_ack_err", 64'({ack, err, ch_rd_valid}), 64'(5'b11000));
    chk("tmo_read_export", 64'(read_export), 64'(exp_rd_now));
    ctl = 2'b00;
    @(negedge clk);
    chk("tmo_ack_drop", 64'(ack), 64'(0));
`else
    begin
      int seen;
      seen = 0;
      address = 8'h05; ctl = 2'b10; ch_ready = 3'b110; ch_rvalid = 3'b111;
      repeat (1000) begin
        @(negedge clk);
        if (ack) seen++;
      end
      chk("no_tmo_ack", 64'(seen), 64'(0));
      chk("no_tmo_valid_held", 64'(ch_rd_valid), 64'(3'b001));
      ctl = 2'b00; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end
`endif

    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wpa2_pio_bridge.md
# wpa2_pio_bridge

Parametrised command bridge between the processor's PIO buses (address, write data, read data, control) and NCH cracking worker channels. It sits next to the wpa2 system. A four-phase request/acknowledge handshake on the control lines drives it. It turns each software access into a single register write or read on one selected channel, and returns read data, error status and an aggregated done flag.

## Interface
- DATA_W, 32, PIO and channel data width
- ADDR_W, 8, PIO address width
- NCH, 4, number of worker channels (≥1); localparam CH_W = max(1, $clog2(NCH)), REG_W = ADDR_W − CH_W
- TIMEOUT, 255, channel response limit in cycles (≥1)

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous, active-low reset
- address_export  in  ADDR_W  [ADDR_W-1:REG_W] channel select, [REG_W-1:0] channel register
- write_export  in  DATA_W  write data
- read_export  out  DATA_W  last successful read data
- control_in_export  in  2  [0] wr_req, [1] rd_req (levels)
- control_out_export  out  3  [0] ack, [1] err, [2] done
- ch_addr  out  REG_W  register address, shared by all channels
- ch_wdata  out  DATA_W  write data, shared by all channels
- ch_wr_valid  out  NCH  one-hot write request
- ch_rd_valid  out  NCH  one-hot read request
- ch_ready  in  NCH  channel accepts the request
- ch_rvalid  in  NCH  read data valid
- ch_rdata  in  NCH*DATA_W  read data, channel i at [i*DATA_W +: DATA_W]
- ch_done  in  NCH  per-channel job done level

## Operation
- FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, ACK.
- IDLE:
  - wr_req or rd_req high → latch address and write data; clear err.
  - Exactly one req high and channel select < NCH → go to WR_ISSUE or RD_ISSUE.
  - Both reqs high, or select ≥ NCH → set err; go to ACK without any channel access.
- WR_ISSUE:
  - Hold ch_wr_valid[sel] with stable ch_addr/ch_wdata until ch_ready[sel] is high.
  - Then drop valid; go to ACK.
- RD_ISSUE: same as WR_ISSUE using ch_rd_valid; on ch_ready[sel] go to RD_WAIT.
- RD_WAIT:
  - On ch_rvalid[sel], capture ch_rdata slice into read_export; go to ACK.
  - ch_rvalid is sampled only in RD_WAIT.
- ACK:
  - ack=1 while in ACK.
  - Leave to IDLE when both reqs are low. If they are already low on entry, ack lasts exactly one cycle.
- Inputs belonging to unselected channels are ignored.
- A req dropped mid-operation does not abort the operation; it completes normally.
- read_export is unchanged by writes and by errored reads.
- done = registered OR of ch_done.
- Reset (any time, including mid-operation): state IDLE. All outputs 0: read_export, ack, err, done, all valids, ch_addr, ch_wdata. Timeout counter 0.

## Timing
- Write: req high in cycle k → ch_wr_valid in k+1 → ack earliest k+2 (ready in k+1).
- Read: rd_valid in k+1 → RD_WAIT in k+2 → read_export and ack earliest k+3 (rvalid in k+2).
- Error path (bad select or both reqs): ack and err in k+1.
- err is valid whenever ack is high and holds until the next request is accepted.
- done lags ch_done by 1 cycle.

## Configuration
- WPA2_PIO_BRIDGE_TIMEOUT_EN defined:
  - A counter runs in WR_ISSUE, RD_ISSUE and RD_WAIT. It is cleared on every state entry.
  - When the count reaches TIMEOUT: drop all valids, set err, go to ACK (read_export unchanged).
- Not defined: no counter; the bridge waits indefinitely for ch_ready/ch_rvalid.

## Structure
- Package wpa2_pio_bridge_pkg holds:
  - state enum
  - control bit indices (CTL_WR_REQ=0, CTL_RD_REQ=1, CTL_ACK=0, CTL_ERR=1, CTL_DONE=2)
- One sub-module, wpa2_pio_bridge_timeout:
  - clear/enable counter with an expired output
  - instantiated only under WPA2_PIO_BRIDGE_TIMEOUT_EN

## Test plan
- Write: address 0x41, data 0x12345678, wr_req, ch1 ready after 3 cycles → ch_wr_valid=0010 for 3 cycles, ch_addr=0x01; ack then err=0; ack drops after wr_req falls.
- Read: address 0x82, rd_req, ch2 ready immediately, rvalid 2 cycles later with 0xCAFEF00D → read_export=0xCAFEF00D at ack, err=0.
- Both reqs high, or address select 3 with NCH=3 → ack and err next cycle; no channel valid ever asserted.
- Timeout (macro on, TIMEOUT=8): ch0 never ready → valid held 8 cycles, then ack with err=1, read_export unchanged. Macro off → no ack after 1000 cycles.
- reset_reset_n pulsed low in RD_WAIT → all outputs 0 immediately. After release with reqs low, bridge stays IDLE; a new read completes normally.
- ch_done=0100 → done=1 one cycle later; ch_done=0 → done=0 one cycle later.
